// File: rtl/ss_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ss_symbol_decoder
// Purpose  : Frame-based stochastic-symbol decoder. Sums exactly
//            2^LEN_LOG2 accepted symbols per frame and holds the sum behind
//            a valid/ready handshake until the consumer takes it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      begin a frame (honoured only in IDLE)
//   clear        in   1      synchronous abort back to IDLE
//   sym_in       in   SYM_W  stochastic symbol
//   sym_valid    in   1      sym_in qualifier
//   sym_ready    out  1      high in RUN
//   busy         out  1      high in RUN and HOLD
//   result       out  OUT_W  frame sum, held until the next frame completes
//   result_valid out  1      high in HOLD
//   result_ready in   1      consumer accept
// ============================================================================
module ss_symbol_decoder #(
    parameter  int SYM_W    = 4,
    parameter  int LEN_LOG2 = 8,
    localparam int OUT_W    = SYM_W + LEN_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             busy,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [OUT_W-1:0]    acc;
    logic [LEN_LOG2-1:0] cnt;
    logic                accept;
    logic                last;
    logic [OUT_W-1:0]    sym_ext;
    logic [OUT_W-1:0]    acc_sum;

    assign accept  = (state == RUN) && sym_valid;
    // The final symbol of a frame is the one accepted while the counter
    // sits at all-ones; the counter then wraps naturally to zero.
    assign last    = accept && (cnt == {LEN_LOG2{1'b1}});
    assign sym_ext = {{LEN_LOG2{1'b0}}, sym_in};
    assign acc_sum = acc + sym_ext;

    // Outputs decode the state register only, so no input reaches an
    // output combinationally.
    assign sym_ready    = (state == RUN);
    assign busy         = (state == RUN) || (state == HOLD);
    assign result_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)        next_state = RUN;
                RUN:     if (last)         next_state = HOLD;
                HOLD:    if (result_ready) next_state = IDLE;
                default:                   next_state = IDLE;
            endcase
        end
    end

    // Datapath. clear wins over everything; result is deliberately left
    // untouched by clear so the last completed frame remains readable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if ((state == IDLE) && start) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt + {{(LEN_LOG2-1){1'b0}}, 1'b1};
            if (last) begin
                result <= acc_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ss_symbol_decoder.md
# ss_symbol_decoder

Frame-based decoder that converts a stream of stochastic symbols back into a binary magnitude. It is the receive/decode end of the stochastic-symbol datapath. Upstream generator and operator stages emit one multi-bit symbol per cycle. This block counts exactly 2^LEN_LOG2 valid symbols per frame, sums them, and presents the sum with a valid/ready handshake. It replaces the free-running accumulator with a bounded frame, a start/clear control, and a held result.

## Interface

- SYM_W, 4: symbol width in bits; symbol value range 0..2^SYM_W-1 (2-bit operands give 4-bit product symbols)
- LEN_LOG2, 8: log2 of the frame length; frame = 256 symbols by default
- OUT_W, SYM_W+LEN_LOG2: result width; derived, not to be overridden

- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE
- clear  input  1  synchronous abort; returns to IDLE from any state
- sym_in  input  SYM_W  stochastic symbol
- sym_valid  input  1  sym_in qualifier
- sym_ready  output  1  high only in RUN; a symbol is accepted when sym_valid && sym_ready
- busy  output  1  high in RUN and HOLD
- result  output  OUT_W  frame sum; stable while result_valid is high
- result_valid  output  1  high in HOLD
- result_ready  input  1  consumer accept

## Operation

- **States:** IDLE, RUN, HOLD. Encoding is free.
- **IDLE:**
  - On start: go to RUN, zero the accumulator acc, and zero the symbol counter cnt (LEN_LOG2 bits).
  - sym_valid is ignored.
- **RUN, on each accepted symbol:**
  - acc <= acc + zero-extended sym_in.
  - cnt <= cnt + 1.
- **RUN, on the accepted symbol where cnt == 2^LEN_LOG2-1:**
  - result <= acc + sym_in.
  - Go to HOLD. cnt wraps to 0.
- **RUN, other inputs:**
  - Cycles with sym_valid low do not advance cnt and do not change acc. Gaps are legal and unbounded.
  - start in RUN is ignored.
- **HOLD:**
  - result_valid=1.
  - When result_ready is high at a clock edge, go to IDLE. result keeps its value afterwards until the next frame completes.
  - start in HOLD is ignored. No back-to-back frame is started from HOLD.
  - Symbols are not accepted.
- **clear:**
  - Has priority over start, symbol acceptance and result_ready.
  - Next state is IDLE; acc and cnt go to 0; result is unchanged.
  - result_valid drops the cycle after clear.
- **Arithmetic:**
  - Unsigned throughout.
  - Max sum (2^SYM_W-1)·2^LEN_LOG2 is less than 2^OUT_W, so no overflow or saturation logic is needed. Defaults give a max of 15·256 = 3840 in 12 bits.
  - Decoded mean = result / 2^LEN_LOG2, i.e. a fixed-point reinterpretation with no divider.

## Timing

- **Reset values:**
  - sym_ready=0, busy=0, result_valid=0, result=0.
  - State IDLE, acc=0, cnt=0.
- **Reset mid-frame:** rst asserted at any time immediately forces the reset values. A partial frame is discarded.
- **Start latency:** start sampled high in IDLE at edge N; sym_ready and busy are high from cycle N+1. The first symbol can be accepted at edge N+1.
- **Result latency:** last symbol accepted at edge M; result and result_valid are valid from cycle M+1. No extra pipeline stage.
- **Minimum frame time:** 2^LEN_LOG2 cycles with sym_valid held high, plus 1 start cycle and at least 1 HOLD cycle.
- **Release:** result_ready high at edge K in HOLD; result_valid and busy are low from K+1. start may be honoured at edge K+1 at the earliest.
- **Outputs:** all registered or decoded from the state register only; no combinational path from any input to any output.

## Test plan

- **All-max frame:** start, then 256 symbols of 15 with sym_valid continuous → result=3840. result_valid rises exactly 1 cycle after the 256th accept.
- **Mixed frame with gaps:**
  - Stimulus: alternating symbols 4 and 9 with sym_valid toggling 1,0 every cycle.
  - Response: result=1664 after 256 accepted symbols, about 512 cycles. Zero frame (all symbols 0) → result=0, result_valid still asserted.
- **Backpressure:**
  - Stimulus: hold result_ready low for 5 cycles in HOLD; drive sym_valid high and pulse start during those cycles.
  - Response: result_valid stays 1 and result stable; sym_ready=0; no new frame starts. result_ready=1 → IDLE next cycle.
- **Clear:**
  - Clear after 100 symbols of 7 → IDLE, busy=0. A new frame of 256 symbols of 1 → result=256, with no residue from the aborted frame.
  - Clear asserted together with start in IDLE → stays IDLE.
- **Async reset:** rst asserted mid-frame, away from any clock edge → all outputs 0 immediately. After release, a full frame of symbols of 2 → result=512.
- **Start in RUN:** start pulsed at symbol 50 of a frame of 3s → ignored; cnt not reset; result=768 after 256 symbols.
